product_accumulator: RTL and testbench

Downstream stage of the 4x4 array multiplier. Consumes its 8-bit product stream over a valid/ready handshake and sums COUNT consecutive products into one dot-product result. Presents that result on a valid/ready output port. Lets the tile compute 4-element dot products from multiplier outputs without external adders.

---
 rtl/product_accumulator_pkg.sv | 17 +
 rtl/product_accumulator_if.sv | 31 +++
 rtl/product_accumulator.sv | 76 +++++++
 tb/tb_product_accumulator.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/product_accumulator_pkg.sv
// Shared parameters and types for the product accumulator.
// Product width matches the 4x4 array multiplier output.
package product_accumulator_pkg;

    localparam int PROD_W = 8;
    localparam int COUNT  = 4;

    // Widened so COUNT full-scale products can never wrap.
    localparam int ACC_W = PROD_W + $clog2(COUNT);
    localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } acc_state_e;

endpackage

// File: rtl/product_accumulator_if.sv
// Valid/ready bundle: product stream in, dot-product result out.
// The master side is the producer/consumer surrounding the block.
interface product_accumulator_if;
    import product_accumulator_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] p_in;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  acc_out;

    modport master (
        output in_valid,
        output p_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  acc_out
    );

    modport slave (
        input  in_valid,
        input  p_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output acc_out
    );

endinterface

// File: rtl/product_accumulator.sv
// Sums COUNT consecutive multiplier products into one result.
// Two-state FSM: ACCUM collects products, DONE presents the sum.
module product_accumulator
    import product_accumulator_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  clear,
    output logic                  busy,
    product_accumulator_if.slave  bus
);

    acc_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_out_q;
    logic             out_valid_q;

    logic [ACC_W-1:0] p_ext;
    logic [ACC_W-1:0] acc_sum;
    logic             last;
    logic             first;

    assign p_ext   = ACC_W'(bus.p_in);
    assign acc_sum = acc + p_ext;
    assign first   = (cnt == '0);
    assign last    = (cnt == CNT_W'(COUNT - 1));

    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = out_valid_q;
    assign bus.acc_out   = acc_out_q;
    assign busy          = (state == ACCUM) && !first;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ACCUM;
            cnt         <= '0;
            acc         <= '0;
            acc_out_q   <= '0;
            out_valid_q <= 1'b0;
        end else if (ena) begin
            // clear wins over any transfer; acc_out keeps the old result
            if (clear) begin
                state       <= ACCUM;
                cnt         <= '0;
                acc         <= '0;
                out_valid_q <= 1'b0;
            end else begin
                unique case (state)
                    ACCUM: begin
                        if (bus.in_valid) begin
                            acc <= first ? p_ext : acc_sum;
                            if (last) begin
                                acc_out_q   <= acc_sum;
                                cnt         <= '0;
                                out_valid_q <= 1'b1;
                                state       <= DONE;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end
                    DONE: begin
                        if (bus.out_ready) begin
                            out_valid_q <= 1'b0;
                            state       <= ACCUM;
                        end
                    end
                    default: state <= ACCUM;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: vector table, directed corners,
// and random traffic against a queue-based dot-product model.
module tb_product_accumulator;
    import product_accumulator_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ena = 1'b0;
    logic clear = 1'b0;
    logic busy;

    product_accumulator_if bus();

    product_accumulator dut (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .clear (clear),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: products collected since last result/abort.
    int m_q[$];
    bit m_pending = 0;
    int m_last = 0;

    typedef struct {
        bit ena;
        bit clr;
        bit iv;
        int p;
        bit ordy;
        bit e_ov;
        bit e_ir;
        int e_ao;
        bit e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pending = 0;
        m_last = 0;
    endtask

    task automatic model_step();
        int s;
        if (!ena) return;
        if (clear) begin
            m_q.delete();
            m_pending = 0;
        end else if (!m_pending) begin
            if (bus.in_valid) begin
                m_q.push_back(int'(bus.p_in));
                if (m_q.size() == COUNT) begin
                    s = 0;
                    foreach (m_q[i]) s += m_q[i];
                    m_last = s;
                    m_pending = 1;
                    m_q.delete();
                end
            end
        end else if (bus.out_ready) begin
            m_pending = 0;
        end
    endtask

    task automatic model_check(input string tag);
        chk({tag, ".out_valid"}, int'(bus.out_valid), int'(m_pending));
        chk({tag, ".in_ready"}, int'(bus.in_ready), int'(!m_pending));
        chk({tag, ".acc_out"}, int'(bus.acc_out), m_last);
        chk({tag, ".busy"}, int'(busy), int'(!m_pending && m_q.size() != 0));
    endtask

    task automatic cycle(input bit e, input bit c, input bit iv,
                         input int p, input bit ordy, input string tag);
        ena = e;
        clear = c;
        bus.in_valid = iv;
        bus.p_in = PROD_W'(p);
        bus.out_ready = ordy;
        model_step();
        @(posedge clk);
        #1;
        model_check(tag);
    endtask

    function automatic vec_t mk(bit iv, int p, bit ordy,
                                bit ov, bit ir, int ao, bit bz);
        vec_t v;
        v.ena = 1; v.clr = 0; v.iv = iv; v.p = p; v.ordy = ordy;
        v.e_ov = ov; v.e_ir = ir; v.e_ao = ao; v.e_busy = bz;
        return v;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        #12;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid = 0;
        bus.p_in = '0;
        bus.out_ready = 0;

        do_reset();
        chk("rst.out_valid", int'(bus.out_valid), 0);
        chk("rst.in_ready", int'(bus.in_ready), 1);
        chk("rst.acc_out", int'(bus.acc_out), 0);
        chk("rst.busy", int'(busy), 0);

        // 1..4, 225x4, then 0,0,0,1
        vecs.push_back(mk(1, 1, 1, 0, 1, 0, 1));
        vecs.push_back(mk(1, 2, 1, 0, 1, 0, 1));
        vecs.push_back(mk(1, 3, 1, 0, 1, 0, 1));
        vecs.push_back(mk(1, 4, 1, 1, 0, 10, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 10, 0));
        vecs.push_back(mk(1, 225, 1, 0, 1, 10, 1));
        vecs.push_back(mk(1, 225, 1, 0, 1, 10, 1));
        vecs.push_back(mk(1, 225, 1, 0, 1, 10, 1));
        vecs.push_back(mk(1, 225, 1, 1, 0, 900, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 900, 0));
        vecs.push_back(mk(1, 0, 1, 0, 1, 900, 1));
        vecs.push_back(mk(1, 0, 1, 0, 1, 900, 1));
        vecs.push_back(mk(1, 0, 1, 0, 1, 900, 1));
        vecs.push_back(mk(1, 1, 1, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1, 0));

        foreach (vecs[i]) begin
            cycle(vecs[i].ena, vecs[i].clr, vecs[i].iv,
                  vecs[i].p, vecs[i].ordy, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.ov", i), int'(bus.out_valid), int'(vecs[i].e_ov));
            chk($sformatf("vec%0d.ir", i), int'(bus.in_ready), int'(vecs[i].e_ir));
            chk($sformatf("vec%0d.ao", i), int'(bus.acc_out), vecs[i].e_ao);
            chk($sformatf("vec%0d.busy", i), int'(busy), int'(vecs[i].e_busy));
        end

        // backpressure: result held for 5 cycles
        for (int i = 1; i <= 4; i++) cycle(1, 0, 1, i, 0, "bp.fill");
        for (int i = 0; i < 5; i++) begin
            cycle(1, 0, 1, 99, 0, "bp.hold");
            chk("bp.ov", int'(bus.out_valid), 1);
            chk("bp.ir", int'(bus.in_ready), 0);
            chk("bp.ao", int'(bus.acc_out), 10);
        end
        cycle(1, 0, 0, 0, 1, "bp.release");
        chk("bp.ir_after", int'(bus.in_ready), 1);

        // clear mid-accumulation, product in same cycle dropped
        cycle(1, 0, 1, 7, 0, "clr.a");
        cycle(1, 0, 1, 9, 0, "clr.b");
        cycle(1, 1, 1, 50, 0, "clr.pulse");
        chk("clr.busy", int'(busy), 0);
        for (int i = 0; i < 4; i++) cycle(1, 0, 1, 1, 0, "clr.ones");
        chk("clr.result", int'(bus.acc_out), 4);
        // clear in DONE discards pending result
        cycle(1, 1, 0, 0, 0, "clr.done");
        chk("clr.done.ov", int'(bus.out_valid), 0);
        chk("clr.done.ao", int'(bus.acc_out), 4);

        // ena toggling with in_valid held
        for (int i = 0; i < 7; i++) cycle(i % 2 == 0, 0, 1, 5, 0, "ena.tog");
        chk("ena.result", int'(bus.acc_out), 20);
        chk("ena.ov", int'(bus.out_valid), 1);
        cycle(0, 0, 0, 0, 1, "ena.frozen");
        chk("ena.frozen.ov", int'(bus.out_valid), 1);
        cycle(1, 0, 0, 0, 1, "ena.drain");

        // asynchronous reset between edges
        cycle(1, 0, 1, 3, 0, "ar.a");
        cycle(1, 0, 1, 3, 0, "ar.b");
        #2;
        rst = 1'b1;
        #1;
        chk("ar.ov", int'(bus.out_valid), 0);
        chk("ar.busy", int'(busy), 0);
        chk("ar.ao", int'(bus.acc_out), 0);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) cycle(1, 0, 1, 2, 0, "ar.twos");
        chk("ar.result", int'(bus.acc_out), 8);
        cycle(1, 0, 0, 0, 1, "ar.drain");

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 9) != 0,
                  $urandom_range(0, 29) == 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) * $urandom_range(0, 15),
                  $urandom_range(0, 2) != 0,
                  "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
